watch_timer_core: RTL and testbench

Parametrised three-engine timekeeping core: free-running time-of-day watch, start/stop stopwatch, and settable countdown timer, all driven by one shared tick generator. A mode select routes the button events to one engine and picks which engine's time fields appear on the outputs. Non-selected engines keep running in the background. It sits between the board-level button debouncers and the FND/display driver.

---
 rtl/watch_pkg.sv | 17 +
 rtl/watch_timer_core_if.sv | 21 ++
 rtl/tick_gen.sv | 16 +
 rtl/watch_timer_core.sv | 174 +++++++++++++++++
 tb/tb_watch_timer_core.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/watch_pkg.sv
// watch_pkg: mode encodings, engine state types and field helpers for watch_timer_core
package watch_pkg;
  localparam logic [1:0] MODE_SW = 2'b00;
  localparam logic [1:0] MODE_WATCH = 2'b01;
  localparam logic [1:0] MODE_CD = 2'b10;
  typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_STOP} sw_state_t;
  typedef enum logic [1:0] {CD_SET, CD_RUN, CD_PAUSE, CD_DONE} cd_state_t;
  function automatic int fw(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int unsigned winc(int unsigned v, int unsigned m);
    return v + 1 >= m ? 32'd0 : v + 1;
  endfunction
  function automatic int unsigned wdec(int unsigned v, int unsigned m);
    return v == 0 ? m - 1 : v - 1;
  endfunction
endpackage

// File: rtl/watch_timer_core_if.sv
// watch_timer_core_if: button/mode inputs and display/status outputs of watch_timer_core
interface watch_timer_core_if import watch_pkg::*; #(
  parameter int TICK_HZ = 100,
  parameter int SECOND_60 = 60,
  parameter int HOUR = 24
);
  logic [1:0] mode;
  logic btn_run, btn_clear, btn_h, btn_m, btn_s;
  logic [fw(TICK_HZ)-1:0] msec;
  logic [fw(SECOND_60)-1:0] sec, min;
  logic [fw(HOUR)-1:0] hour;
  logic running, expired, tick_100hz, tick_1s;
  modport master (
    output mode, btn_run, btn_clear, btn_h, btn_m, btn_s,
    input msec, sec, min, hour, running, expired, tick_100hz, tick_1s
  );
  modport slave (
    input mode, btn_run, btn_clear, btn_h, btn_m, btn_s,
    output msec, sec, min, hour, running, expired, tick_100hz, tick_1s
  );
endinterface

// File: rtl/tick_gen.sv
// tick_gen: one-cycle tick every CLK_HZ/TICK_HZ clocks, shared by all engines
module tick_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic clk,
  input  logic reset,
  output logic tick_100hz
);
  localparam int N = CLK_HZ / TICK_HZ;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  logic [CW-1:0] cnt;
  assign tick_100hz = cnt == CW'(N - 1);
  always_ff @(posedge clk)
    cnt <= (reset || tick_100hz) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/watch_timer_core.sv
// watch_timer_core: watch, stopwatch and countdown engines on a shared tick; LAP_EN adds stopwatch lap freeze
module watch_timer_core import watch_pkg::*; #(
  parameter int CLK_HZ = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter int SECOND_60 = 60,
  parameter int HOUR = 24
) (
  input logic clk,
  input logic reset,
  watch_timer_core_if.slave bus
);
  localparam int MW = fw(TICK_HZ);
  localparam int SW = fw(SECOND_60);
  localparam int HW = fw(HOUR);
  typedef struct packed {
    logic [HW-1:0] hour;
    logic [SW-1:0] min;
    logic [SW-1:0] sec;
    logic [MW-1:0] msec;
  } tm_t;
  localparam int TW = $bits(tm_t);

  function automatic tm_t inc(tm_t t);
    tm_t r;
    r = t;
    r.msec = MW'(winc(32'(t.msec), TICK_HZ));
    if (t.msec == MW'(TICK_HZ - 1)) begin
      r.sec = SW'(winc(32'(t.sec), SECOND_60));
      if (t.sec == SW'(SECOND_60 - 1)) begin
        r.min = SW'(winc(32'(t.min), SECOND_60));
        if (t.min == SW'(SECOND_60 - 1)) r.hour = HW'(winc(32'(t.hour), HOUR));
      end
    end
    return r;
  endfunction

  function automatic tm_t dec(tm_t t);
    tm_t r;
    r = t;
    r.msec = MW'(wdec(32'(t.msec), TICK_HZ));
    if (t.msec == '0) begin
      r.sec = SW'(wdec(32'(t.sec), SECOND_60));
      if (t.sec == '0) begin
        r.min = SW'(wdec(32'(t.min), SECOND_60));
        if (t.min == '0) r.hour = HW'(wdec(32'(t.hour), HOUR));
      end
    end
    return r;
  endfunction

  // Button field edits never carry into the next field
  function automatic tm_t bump(tm_t t, logic h, logic m, logic s);
    tm_t r;
    r = t;
    if (h) r.hour = HW'(winc(32'(t.hour), HOUR));
    if (m) r.min = SW'(winc(32'(t.min), SECOND_60));
    if (s) begin
      r.sec = SW'(winc(32'(t.sec), SECOND_60));
      r.msec = '0;
    end
    return r;
  endfunction

  logic tick;
  tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk(clk), .reset(reset), .tick_100hz(tick)
  );

  logic [4:0] btn, btn_q, ev;
  logic e_run, e_clr, e_h, e_m, e_s;
  assign btn = {bus.btn_run, bus.btn_clear, bus.btn_h, bus.btn_m, bus.btn_s};
  assign {e_run, e_clr, e_h, e_m, e_s} = ev;
  always_ff @(posedge clk) begin
    btn_q <= reset ? '0 : btn;
    ev <= reset ? '0 : btn & ~btn_q;
  end

  logic sel_sw, sel_cd, sel_w;
  assign sel_sw = bus.mode == MODE_SW;
  assign sel_cd = bus.mode == MODE_CD;
  assign sel_w = bus.mode == MODE_WATCH || bus.mode == 2'b11;

  tm_t w;
  always_ff @(posedge clk)
    w <= reset ? '0 : bump(tick ? inc(w) : w, sel_w && e_h, sel_w && e_m, sel_w && e_s);

  sw_state_t sw;
  tm_t s, s_t, sw_disp;
  assign s_t = (sw == SW_RUN && tick) ? inc(s) : s;
`ifdef LAP_EN
  logic frozen;
  tm_t lap;
  assign sw_disp = frozen ? lap : s;
`else
  assign sw_disp = s;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      sw <= SW_IDLE;
      s <= '0;
`ifdef LAP_EN
      frozen <= 1'b0;
      lap <= '0;
`endif
    end else begin
      s <= s_t;
      if (sel_sw && e_clr) begin
        if (sw != SW_RUN) begin
          s <= '0;
          sw <= SW_IDLE;
`ifdef LAP_EN
          frozen <= 1'b0;
`endif
        end
`ifdef LAP_EN
        else begin
          frozen <= !frozen;
          lap <= s_t;
        end
`endif
      end else if (sel_sw && e_run)
        sw <= sw == SW_RUN ? SW_STOP : SW_RUN;
    end
  end

  // Tick effect is resolved first so that edits and button events see the post-tick state
  cd_state_t cd, cd_t;
  tm_t p, c, c_t;
  logic expired, x_t, tk_cd, c_hit;
  assign tk_cd = cd == CD_RUN && tick;
  assign c_hit = c == TW'(1);
  assign c_t = tk_cd ? dec(c) : c;
  assign cd_t = (tk_cd && c_hit) ? CD_DONE : cd;
  assign x_t = expired || (tk_cd && c_hit);
  always_ff @(posedge clk) begin
    if (reset) begin
      cd <= CD_SET;
      p <= '0;
      c <= '0;
      expired <= 1'b0;
    end else begin
      cd <= cd_t;
      c <= c_t;
      expired <= x_t;
      if (sel_cd && e_clr) begin
        if (cd_t == CD_SET) p <= '0;
        else if (cd_t != CD_RUN) begin
          cd <= CD_SET;
          expired <= 1'b0;
        end
      end else if (sel_cd) begin
        if (e_run) begin
          if (cd_t == CD_SET && p != '0) begin
            c <= p;
            cd <= CD_RUN;
          end else if (cd_t == CD_RUN || cd_t == CD_PAUSE)
            cd <= cd_t == CD_RUN ? CD_PAUSE : CD_RUN;
        end
        if (cd_t == CD_SET) p <= bump(p, e_h, e_m, e_s);
      end
    end
  end

  tm_t d;
  assign d = sel_sw ? sw_disp : sel_cd ? (cd == CD_SET ? p : c) : w;
  assign bus.msec = d.msec;
  assign bus.sec = d.sec;
  assign bus.min = d.min;
  assign bus.hour = d.hour;
  assign bus.running = sel_sw ? sw == SW_RUN : sel_cd ? cd == CD_RUN : 1'b1;
  assign bus.expired = expired;
  assign bus.tick_100hz = tick;
  assign bus.tick_1s = tick && w.msec == MW'(TICK_HZ - 1);
endmodule

// File: tb/tb_watch_timer_core.sv
// tb_watch_timer_core: randomized and directed checks of watch_timer_core against a tick-count model
module tb_watch_timer_core;
  localparam int DAY = 24 * 60 * 60 * 100;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  watch_timer_core_if #(.TICK_HZ(100), .SECOND_60(60), .HOUR(24)) bus ();
  watch_timer_core #(.CLK_HZ(1000), .TICK_HZ(100), .SECOND_60(60), .HOUR(24)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int fails = 0;

  // Model keeps every time as a total count of ticks
  int m_tc, m_w, m_s, m_sw, m_p, m_c, m_cd, st;
  logic m_exp, tk;
  logic [4:0] m_prev, m_ev, e;
  logic [1:0] md;
  logic [4:0] btns;
  logic [23:0] disp;
  assign btns = {bus.btn_run, bus.btn_clear, bus.btn_h, bus.btn_m, bus.btn_s};
  assign disp = {bus.hour, bus.min, bus.sec, bus.msec};

  function automatic int inc_h(int t);
    return t + (((t / 360000) + 1) % 24 - t / 360000) * 360000;
  endfunction
  function automatic int inc_m(int t);
    return t + ((((t / 6000) % 60) + 1) % 60 - (t / 6000) % 60) * 6000;
  endfunction
  function automatic int inc_s(int t);
    return t - t % 100 + ((((t / 100) % 60) + 1) % 60 - (t / 100) % 60) * 100;
  endfunction
  function automatic logic [23:0] pack(int t);
    return {5'(t / 360000), 6'((t / 6000) % 60), 6'((t / 100) % 60), 7'(t % 100)};
  endfunction
  function automatic logic [23:0] exp_disp();
    return bus.mode == 2'd0 ? pack(m_s) : bus.mode == 2'd2 ? pack(m_cd == 0 ? m_p : m_c) : pack(m_w);
  endfunction
  function automatic logic exp_run();
    return bus.mode == 2'd0 ? m_sw == 1 : bus.mode == 2'd2 ? m_cd == 1 : 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_tc = 0; m_w = 0; m_s = 0; m_sw = 0; m_p = 0; m_c = 0; m_cd = 0;
      m_exp = 1'b0; m_prev = '0; m_ev = '0;
    end else begin
      tk = m_tc == 9;
      e = m_ev;
      md = bus.mode;
      if (tk) m_w = (m_w + 1) % DAY;
      if (md == 2'd1 || md == 2'd3) begin
        if (e[2]) m_w = inc_h(m_w);
        if (e[1]) m_w = inc_m(m_w);
        if (e[0]) m_w = inc_s(m_w);
      end
      if (tk && m_sw == 1) m_s = (m_s + 1) % DAY;
      if (md == 2'd0) begin
        if (e[3]) begin
          if (m_sw != 1) begin m_s = 0; m_sw = 0; end
        end else if (e[4]) m_sw = m_sw == 1 ? 2 : 1;
      end
      if (tk && m_cd == 1) begin
        m_c = m_c - 1;
        if (m_c == 0) begin m_cd = 3; m_exp = 1'b1; end
      end
      if (md == 2'd2) begin
        st = m_cd;
        if (e[3]) begin
          if (st == 0) m_p = 0;
          else if (st != 1) begin m_cd = 0; m_exp = 1'b0; end
        end else begin
          if (e[4]) begin
            if (st == 0 && m_p != 0) begin m_c = m_p; m_cd = 1; end
            else if (st == 1) m_cd = 2;
            else if (st == 2) m_cd = 1;
          end
          if (st == 0) begin
            if (e[2]) m_p = inc_h(m_p);
            if (e[1]) m_p = inc_m(m_p);
            if (e[0]) m_p = inc_s(m_p);
          end
        end
      end
      m_ev = btns & ~m_prev;
      m_prev = btns;
      m_tc = (m_tc + 1) % 10;
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(int b, logic v);
    if (b == 4) bus.btn_run = v;
    else if (b == 3) bus.btn_clear = v;
    else if (b == 2) bus.btn_h = v;
    else if (b == 1) bus.btn_m = v;
    else bus.btn_s = v;
  endtask

  // Called at a negedge; returns at the negedge where the event has taken effect
  task automatic press(int b);
    set_btn(b, 1'b1);
    @(negedge clk);
    set_btn(b, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_reset(logic [1:0] m);
    @(negedge clk);
    reset = 1'b1;
    bus.mode = m;
    {bus.btn_run, bus.btn_clear, bus.btn_h, bus.btn_m, bus.btn_s} = '0;
    idle(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2'd1);
    reset = 1'b1;
    #1;
    checks++; if (disp !== 24'd0) begin fails++; $display("FAIL reset_fields: got %h want 0", disp); end
    checks++; if (bus.running !== 1'b1) begin fails++; $display("FAIL reset_running_watch: got %b want 1", bus.running); end
    checks++; if ({bus.expired, bus.tick_100hz, bus.tick_1s} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {bus.expired, bus.tick_100hz, bus.tick_1s}); end
    bus.mode = 2'd0;
    #1;
    checks++; if (bus.running !== 1'b0) begin fails++; $display("FAIL reset_running_sw: got %b want 0", bus.running); end
    @(negedge clk);
    reset = 1'b0;
    idle(8);
    checks++; if (bus.tick_100hz !== 1'b0) begin fails++; $display("FAIL tick_early: got %b want 0", bus.tick_100hz); end
    idle(1);
    checks++; if (bus.tick_100hz !== 1'b1) begin fails++; $display("FAIL tick_first: got %b want 1", bus.tick_100hz); end
  endtask

  task automatic test_watch_minute();
    int ones = 0;
    do_reset(2'd1);
    repeat (60000) begin
      @(negedge clk);
      if (bus.tick_1s === 1'b1) ones++;
    end
    checks++; if (disp !== {5'd0, 6'd1, 6'd0, 7'd0}) begin fails++; $display("FAIL watch_minute: got %h want %h", disp, {5'd0, 6'd1, 6'd0, 7'd0}); end
    checks++; if (ones != 60) begin fails++; $display("FAIL tick_1s_count: got %0d want 60", ones); end
    checks++; if (disp !== exp_disp()) begin fails++; $display("FAIL watch_minute_model: got %h want %h", disp, exp_disp()); end
  endtask

  task automatic test_watch_wrap();
    int n = 0;
    logic seen = 1'b0;
    do_reset(2'd1);
    @(negedge clk);
    repeat (23) press(2);
    repeat (59) press(1);
    repeat (59) press(0);
    for (int i = 0; i < 2000 && bus.msec != 7'd99; i++) @(negedge clk);
    checks++; if (disp !== {5'd23, 6'd59, 6'd59, 7'd99}) begin fails++; $display("FAIL watch_preset: got %h want %h", disp, {5'd23, 6'd59, 6'd59, 7'd99}); end
    while (bus.msec == 7'd99 && n < 20) begin
      if (bus.tick_1s === 1'b1) seen = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++; if (disp !== 24'd0) begin fails++; $display("FAIL watch_wrap: got %h want 0", disp); end
    checks++; if (seen !== 1'b1) begin fails++; $display("FAIL watch_wrap_1s: got %b want 1", seen); end
  endtask

  task automatic test_stopwatch();
    do_reset(2'd0);
    @(negedge clk);
    press(4);
    for (int i = 0; i < 3000 && disp != {5'd0, 6'd0, 6'd1, 7'd50}; i++) @(negedge clk);
    press(4);
    idle(3);
    checks++; if (disp !== {5'd0, 6'd0, 6'd1, 7'd50}) begin fails++; $display("FAIL sw_stop: got %h want %h", disp, {5'd0, 6'd0, 6'd1, 7'd50}); end
    checks++; if (bus.running !== 1'b0) begin fails++; $display("FAIL sw_stop_running: got %b want 0", bus.running); end
    press(3);
    checks++; if ({disp, bus.running} !== 25'd0) begin fails++; $display("FAIL sw_clear: got %h want 0", {disp, bus.running}); end
    press(4);
    idle(37);
    press(3);
    checks++; if (bus.running !== 1'b1) begin fails++; $display("FAIL sw_clear_run: got %b want 1", bus.running); end
    checks++; if (disp !== exp_disp() || disp == 24'd0) begin fails++; $display("FAIL sw_clear_ignored: got %h want %h", disp, exp_disp()); end
    press(4);
    checks++; if (disp !== exp_disp() || bus.running !== 1'b0) begin fails++; $display("FAIL sw_resume_stop: got %h want %h", disp, exp_disp()); end
  endtask

  task automatic test_countdown();
    int i;
    do_reset(2'd2);
    @(negedge clk);
    press(0);
    press(0);
    checks++; if (disp !== {5'd0, 6'd0, 6'd2, 7'd0}) begin fails++; $display("FAIL cd_preset: got %h want %h", disp, {5'd0, 6'd0, 6'd2, 7'd0}); end
    press(4);
    checks++; if (bus.running !== 1'b1) begin fails++; $display("FAIL cd_running: got %b want 1", bus.running); end
    for (i = 0; i < 3000 && bus.expired !== 1'b1; i++) begin
      @(negedge clk);
      checks++; if (disp !== exp_disp() || bus.expired !== m_exp) begin fails++; $display("FAIL cd_count: got %h/%b want %h/%b", disp, bus.expired, exp_disp(), m_exp); end
    end
    checks++; if (i >= 3000) begin fails++; $display("FAIL cd_timeout: got no expiry want expired within 3000 cycles"); end
    checks++; if ({disp, bus.running} !== 25'd0) begin fails++; $display("FAIL cd_done: got %h want 0", {disp, bus.running}); end
    press(3);
    checks++; if (bus.expired !== 1'b0) begin fails++; $display("FAIL cd_clear_exp: got %b want 0", bus.expired); end
    checks++; if (disp !== {5'd0, 6'd0, 6'd2, 7'd0}) begin fails++; $display("FAIL cd_clear_disp: got %h want %h", disp, {5'd0, 6'd0, 6'd2, 7'd0}); end
  endtask

  task automatic test_zero_preset();
    do_reset(2'd2);
    @(negedge clk);
    press(4);
    checks++; if ({disp, bus.running, bus.expired} !== 26'd0) begin fails++; $display("FAIL cd_zero_run: got %h want 0", {disp, bus.running, bus.expired}); end
    press(1);
    checks++; if (disp !== {5'd0, 6'd1, 6'd0, 7'd0}) begin fails++; $display("FAIL cd_set_min: got %h want %h", disp, {5'd0, 6'd1, 6'd0, 7'd0}); end
    press(3);
    checks++; if (disp !== 24'd0) begin fails++; $display("FAIL cd_set_clear: got %h want 0", disp); end
  endtask

  task automatic test_mode_switch();
    int snap;
    do_reset(2'd0);
    @(negedge clk);
    press(4);
    idle(123);
    snap = m_s;
    bus.mode = 2'd1;
    #1;
    checks++; if (disp !== pack(m_w)) begin fails++; $display("FAIL switch_watch: got %h want %h", disp, pack(m_w)); end
    idle(1000);
    bus.mode = 2'd0;
    #1;
    checks++; if (disp !== pack(snap + 100) || bus.running !== 1'b1) begin fails++; $display("FAIL switch_back: got %h want %h", disp, pack(snap + 100)); end
  endtask

  task automatic test_random();
    do_reset(2'(($urandom % 3)));
    repeat (4000) begin
      @(negedge clk);
      checks++; if (disp !== exp_disp()) begin fails++; $display("FAIL rnd_disp: got %h want %h", disp, exp_disp()); end
      checks++; if (bus.running !== exp_run()) begin fails++; $display("FAIL rnd_running: got %b want %b", bus.running, exp_run()); end
      checks++; if (bus.expired !== m_exp) begin fails++; $display("FAIL rnd_expired: got %b want %b", bus.expired, m_exp); end
      checks++; if (bus.tick_100hz !== (m_tc == 9)) begin fails++; $display("FAIL rnd_tick: got %b want %b", bus.tick_100hz, m_tc == 9); end
      checks++; if (bus.tick_1s !== (m_tc == 9 && m_w % 100 == 99)) begin fails++; $display("FAIL rnd_tick_1s: got %b want %b", bus.tick_1s, m_tc == 9 && m_w % 100 == 99); end
      if ($urandom % 60 == 0) bus.mode = 2'($urandom % 4);
      if ($urandom % 6 == 0) bus.btn_run = ~bus.btn_run;
      if ($urandom % 10 == 0) bus.btn_clear = ~bus.btn_clear;
      if ($urandom % 80 == 0) bus.btn_h = ~bus.btn_h;
      if ($urandom % 40 == 0) bus.btn_m = ~bus.btn_m;
      if ($urandom % 5 == 0) bus.btn_s = ~bus.btn_s;
      reset = $urandom % 700 == 0;
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.mode = 2'd1;
    {bus.btn_run, bus.btn_clear, bus.btn_h, bus.btn_m, bus.btn_s} = '0;
    test_reset();
    test_watch_minute();
    test_watch_wrap();
    test_stopwatch();
    test_countdown();
    test_zero_preset();
    test_mode_switch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
